// File: rtl/md_iter_unit.sv
`default_nettype none
// ============================================================================
// Module      : md_iter_unit
// Description : Iterative radix-2 multiply/divide unit owning HI/LO.
//               Shift-add multiply, restoring divide, optional MADD/MSUB
//               accumulate, cancel, done/div0 status.
// Revision    : 1.0 - initial release
// ============================================================================
module md_iter_unit #(
    parameter int WIDTH      = 32,
    parameter bit ENABLE_ACC = 1'b1
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic [1:0]       hilo_wr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             cancel_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             div0_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;          // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] prod_q, prod_d;    // product, or {remainder, dividend/quotient}
    logic [2:0]         op_q, op_d;
    logic               neg_q, neg_d;      // product / quotient must be negated
    logic               negr_q, negr_d;    // remainder must be negated
    logic               dz_q, dz_d;        // divide by zero detected at launch
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d, div0_q, div0_d;

    // Launch-side decode of the incoming operation
    logic [2:0]         op_eff;
    logic               in_div, in_sgn, a_neg, b_neg, hilo_write;
    logic [WIDTH-1:0]   abs_a, abs_b;

    // One-bit iteration datapath and final sign correction
    logic [WIDTH:0]     mul_sum, div_sh, div_rem;
    logic               div_ge, run_div;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_s, acc_res;
    logic [WIDTH-1:0]   quot_s, rem_s;

    // Operand decode and per-cycle shift-add / restoring-subtract step
    always_comb begin
        op_eff     = ENABLE_ACC ? op_i : {1'b0, op_i[1:0]};
        in_div     = (op_eff[2:1] == 2'b01);
        in_sgn     = ~op_eff[0];
        a_neg      = in_sgn & src_a_i[WIDTH-1];
        b_neg      = in_sgn & src_b_i[WIDTH-1];
        abs_a      = a_neg ? -src_a_i : src_a_i;
        abs_b      = b_neg ? -src_b_i : src_b_i;
        hilo_write = (hilo_wr_i == 2'b01) || (hilo_wr_i == 2'b10);

        run_div  = (op_q[2:1] == 2'b01);
        mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, prod_q[WIDTH-1:1]};
        div_sh   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        div_ge   = (div_sh >= {1'b0, a_q});
        div_rem  = div_ge ? (div_sh - {1'b0, a_q}) : div_sh;
        div_next = {div_rem[WIDTH-1:0], prod_q[WIDTH-2:0], div_ge};

        prod_s   = neg_q ? -prod_q : prod_q;
        acc_res  = op_q[2] ? (op_q[1] ? ({hi_q, lo_q} - prod_s) : ({hi_q, lo_q} + prod_s)) : prod_s;
        quot_s   = neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
        rem_s    = negr_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
    end

    // Next-state and register-update logic for IDLE / RUN / FIN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        prod_d  = prod_q;
        op_d    = op_q;
        neg_d   = neg_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        div0_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hilo_wr_i == 2'b01) begin
                    hi_d = wr_data_i;
                end else if (hilo_wr_i == 2'b10) begin
                    lo_d = wr_data_i;
                end else if (start_i && !hilo_write) begin
                    op_d  = op_eff;
                    cnt_d = CW'(WIDTH-1);
                    neg_d = a_neg ^ b_neg;
                    dz_d  = in_div && (src_b_i == '0);
                    if (in_div) begin
                        a_d    = abs_b;
                        prod_d = {{WIDTH{1'b0}}, abs_a};
                        negr_d = a_neg;
                    end else begin
                        a_d    = abs_a;
                        prod_d = {{WIDTH{1'b0}}, abs_b};
                        negr_d = 1'b0;
                    end
                    state_d = (in_div && (src_b_i == '0)) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                if (cancel_i) begin
                    state_d = S_IDLE;
                end else begin
                    prod_d = run_div ? div_next : mul_next;
                    cnt_d  = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                div0_d  = dz_q;
                if (!dz_q) begin
                    if (run_div) begin
                        hi_d = rem_s;
                        lo_d = quot_s;
                    end else begin
                        {hi_d, lo_d} = acc_res;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            prod_q  <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            prod_q  <= prod_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
        end
    end

    assign busy_o  = (state_q != S_IDLE);
    assign stall_o = busy_o | start_i;
    assign done_o  = done_q;
    assign div0_o  = div0_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_md_iter_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_iter_unit
// Description : Self-checking bench for md_iter_unit: transaction-level
//               timing/arithmetic model compared every cycle, directed
//               literal cases, random traffic, and an 8-bit instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_iter_unit;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start, cancel, stall, busy, done, div0;
    logic [2:0]    op;
    logic [W-1:0]  a, b, wd, hi, lo;
    logic [1:0]    hw;

    logic          s_start, s_cancel, s_stall, s_busy, s_done, s_div0;
    logic [2:0]    s_op;
    logic [7:0]    s_a, s_b, s_wd, s_hi, s_lo;
    logic [1:0]    s_hw;

    int checks = 0;
    int errors = 0;

    md_iter_unit #(.WIDTH(W), .ENABLE_ACC(1'b1)) dut (
        .clk_i(clk), .reset_ni(rst_n), .start_i(start), .op_i(op),
        .src_a_i(a), .src_b_i(b), .hilo_wr_i(hw), .wr_data_i(wd),
        .cancel_i(cancel), .stall_o(stall), .busy_o(busy), .done_o(done),
        .div0_o(div0), .hi_o(hi), .lo_o(lo)
    );

    md_iter_unit #(.WIDTH(8), .ENABLE_ACC(1'b0)) dut8 (
        .clk_i(clk), .reset_ni(rst_n), .start_i(s_start), .op_i(s_op),
        .src_a_i(s_a), .src_b_i(s_b), .hilo_wr_i(s_hw), .wr_data_i(s_wd),
        .cancel_i(s_cancel), .stall_o(s_stall), .busy_o(s_busy), .done_o(s_done),
        .div0_o(s_div0), .hi_o(s_hi), .lo_o(s_lo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Arithmetic reference: results of one op at width w, computed with 64-bit integers
    function automatic void ref_op(input int w, input bit acc_en, input logic [2:0] opx,
                                   input logic [31:0] av, input logic [31:0] bv,
                                   inout logic [31:0] h, inout logic [31:0] l);
        logic [63:0] mw, m2, ua, ub, p, hl;
        longint      sa, sb, q, r;
        logic [2:0]  e;
        mw = (64'd1 << w) - 64'd1;
        m2 = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2*w)) - 64'd1);
        ua = {32'd0, av} & mw;
        ub = {32'd0, bv} & mw;
        sa = $signed(ua << (64-w)) >>> (64-w);
        sb = $signed(ub << (64-w)) >>> (64-w);
        e  = acc_en ? opx : {1'b0, opx[1:0]};
        if (e[2:1] == 2'b01) begin
            if (e[0]) begin
                q = ua / ub;
                r = ua % ub;
            end else begin
                q = sa / sb;
                r = sa % sb;
            end
            l = 32'(q) & mw[31:0];
            h = 32'(r) & mw[31:0];
        end else begin
            p  = e[0] ? (ua * ub) : 64'(sa * sb);
            hl = (({32'd0, h} & mw) << w) | ({32'd0, l} & mw);
            if (e[2]) hl = e[1] ? (hl - p) : (hl + p);
            else      hl = p;
            hl = hl & m2;
            h  = 32'((hl >> w) & mw);
            l  = 32'(hl & mw);
        end
    endfunction

    // Transaction model of the 32-bit unit: cycles left until done, pending op
    int          left;
    logic        pdz, ed, ez;
    logic [2:0]  pop;
    logic [31:0] pa, pb, eh, el;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left = 0; pdz = 0; ed = 0; ez = 0; eh = 0; el = 0;
        end else begin
            ed = 0;
            ez = 0;
            if (left == 0) begin
                if (hw == 2'b01)      eh = wd;
                else if (hw == 2'b10) el = wd;
                else if (start) begin
                    pop  = op; pa = a; pb = b;
                    pdz  = (op[2:1] == 2'b01) && (b == 0);
                    left = pdz ? 1 : W + 1;
                end
            end else if (left > 1 && cancel) begin
                left = 0;
            end else begin
                left--;
                if (left == 0) begin
                    ed = 1;
                    ez = pdz;
                    if (!pdz) ref_op(W, 1'b1, pop, pa, pb, eh, el);
                end
            end
        end
    end

    // Every-cycle comparison of the 32-bit DUT against the model
    always @(negedge clk) begin
        chk("hi", hi, eh);
        chk("lo", lo, el);
        chk("busy", busy, (left != 0));
        chk("done", done, ed);
        chk("div0", div0, ez);
        chk("stall", stall, (left != 0) | start);
    end

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int lat);
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("done_seen", done, 1);
    endtask

    task automatic run8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, output int lat);
        @(posedge clk); #1;
        s_start = 1'b1; s_op = o; s_a = x; s_b = y;
        @(posedge clk); #1;
        s_start = 1'b0; s_a = 8'($urandom); s_b = 8'($urandom);
        lat = 0;
        while (!s_done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("w8_done_seen", s_done, 1);
    endtask

    task automatic mt(input logic [1:0] sel, input logic [31:0] v);
        @(posedge clk); #1;
        hw = sel; wd = v;
        @(posedge clk); #1;
        hw = 2'b00;
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom % 8)
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h1;
            4:       return $urandom % 16;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, seen;
        logic [31:0] mh, ml;
        rst_n = 0; start = 0; cancel = 0; hw = 0; op = 0; a = 0; b = 0; wd = 0;
        s_start = 0; s_cancel = 0; s_hw = 0; s_op = 0; s_a = 0; s_b = 0; s_wd = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1;

        // MULT -2 * 3
        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, lat);
        chk("t1_lat", lat, 33);
        chk("t1_hi", hi, 32'hFFFF_FFFF);
        chk("t1_lo", lo, 32'hFFFF_FFFA);

        // DIV -7 / 2 and DIVU 7 / 2
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, lat);
        chk("t2_div_lo", lo, 32'hFFFF_FFFD);
        chk("t2_div_hi", hi, 32'hFFFF_FFFF);
        run_op(3'd3, 32'd7, 32'd2, lat);
        chk("t2_divu_lo", lo, 32'd3);
        chk("t2_divu_hi", hi, 32'd1);

        // Divide by zero leaves HI/LO alone
        mt(2'b01, 32'h11);
        mt(2'b10, 32'h22);
        run_op(3'd2, 32'd5, 32'd0, lat);
        chk("t3_lat", lat, 1);
        chk("t3_div0", div0, 1);
        chk("t3_hi", hi, 32'h11);
        chk("t3_lo", lo, 32'h22);

        // Accumulate modes
        mt(2'b01, 32'd1);
        mt(2'b10, 32'hFFFF_FFFF);
        run_op(3'd5, 32'd1, 32'd1, lat);
        chk("t4_maddu_hi", hi, 32'd2);
        chk("t4_maddu_lo", lo, 32'd0);
        run_op(3'd6, 32'd1, 32'd1, lat);
        chk("t4_msub_hi", hi, 32'd1);
        chk("t4_msub_lo", lo, 32'hFFFF_FFFF);

        // Cancel mid-MULTU
        @(posedge clk); #1;
        start = 1; op = 3'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 0;
        repeat (9) begin @(posedge clk); #1; end
        cancel = 1;
        @(posedge clk); #1;
        cancel = 0;
        chk("t5_busy", busy, 0);
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (done) seen++; end
        chk("t5_nodone", seen, 0);
        chk("t5_hi", hi, 32'd1);
        chk("t5_lo", lo, 32'hFFFF_FFFF);

        // MTHI together with start: write only
        hw = 2'b01; wd = 32'hABCD; start = 1; op = 3'd0; a = 5; b = 5;
        @(posedge clk); #1;
        hw = 0; start = 0;
        chk("t5_wr_busy", busy, 0);
        chk("t5_wr_hi", hi, 32'hABCD);

        // Asynchronous reset in the middle of a divide
        @(posedge clk); #1;
        start = 1; op = 3'd2; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("t6_hi", hi, 0);
        chk("t6_lo", lo, 0);
        chk("t6_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1;

        // Signed MIN / -1
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        chk("t6_min_lo", lo, 32'h8000_0000);
        chk("t6_min_hi", hi, 32'd0);

        // Random traffic, every cycle checked against the model
        repeat (3000) begin
            @(posedge clk); #1;
            start  = ($urandom % 4 == 0);
            op     = 3'($urandom);
            a      = rnd_operand();
            b      = rnd_operand();
            hw     = ($urandom % 16 == 0) ? 2'($urandom) : 2'b00;
            wd     = $urandom;
            cancel = ($urandom % 40 == 0);
        end
        @(posedge clk); #1;
        start = 0; hw = 0; cancel = 0;
        repeat (40) @(posedge clk);

        // 8-bit instance without accumulate
        run8(3'd0, 8'hFE, 8'h03, lat);
        chk("w8_lat", lat, 9);
        chk("w8_mult_hi", s_hi, 8'hFF);
        chk("w8_mult_lo", s_lo, 8'hFA);
        run8(3'd2, 8'hF9, 8'h02, lat);
        chk("w8_div_lo", s_lo, 8'hFD);
        chk("w8_div_hi", s_hi, 8'hFF);
        run8(3'd3, 8'h07, 8'h02, lat);
        chk("w8_divu_lo", s_lo, 8'h03);
        chk("w8_divu_hi", s_hi, 8'h01);
        mh = {24'd0, s_hi};
        ml = {24'd0, s_lo};
        ref_op(8, 1'b0, 3'd5, 32'h10, 32'h10, mh, ml);
        run8(3'd5, 8'h10, 8'h10, lat);
        chk("w8_noacc_hi", s_hi, 8'h01);
        chk("w8_noacc_lo", s_lo, 8'h00);
        chk("w8_model_hi", s_hi, mh[7:0]);
        chk("w8_model_lo", s_lo, ml[7:0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
